primus_dmem_responder: RTL
==========================

Name: primus_dmem_responder

Overview:
- Data-memory responder: the target end of the mem_stage access interface driven by the ctrl_t mem_read/mem_write signals.
- Accepts one load or store per handshake, with a funct3 size code (byte/half/word, signed/unsigned).
- Contains a word-organised on-chip RAM, inserts a programmable number of wait states, and returns sign/zero-extended load data or an error response.
- Sits beside mem_stage; mem_stage stalls the pipeline until the response arrives.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two, at least 4.
- WAIT_CYCLES, 1, extra cycles between request acceptance and response; range 0..15.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  1  request valid. Held with all request fields until req_ready_o is sampled high.
- mem_read_i  input  1  load request (ctrl_t.mem_read).
- mem_write_i  input  1  store request (ctrl_t.mem_write).
- funct3_i  input  3  size code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data, right-aligned.
- req_ready_o  output  1  request accepted this cycle when req_i is also high.
- rsp_valid_o  output  1  one-cycle pulse: response valid.
- rsp_rdata_o  output  32  extended load data; 0 for stores and errors.
- rsp_err_o  output  1  access fault; qualified by rsp_valid_o.

Behaviour:
- Reset: FSM to IDLE.
  - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, wait counter=0.
  - RAM contents are not reset.
  - Reset asserted mid-transaction aborts it; no RAM write may occur after reset is asserted.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready_o=1.
    - On req_i: latch all request fields and load the counter with WAIT_CYCLES.
    - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT: req_ready_o=0; counter decrements each cycle; go to RESP when the counter reaches 1.
  - RESP: req_ready_o=0.
    - The store write or the load read of the latched request happens on entry to RESP.
    - rsp_valid_o=1 for exactly one cycle; next state IDLE.
- Latency: the response appears WAIT_CYCLES+1 cycles after the accept edge. Minimum is 1 (registered response).
- Throughput: one request per WAIT_CYCLES+2 cycles.
  - req_ready_o is combinational on state only, never on req_i.
- Illegal requests: both mem_read_i and mem_write_i high, or neither high.
  - Error response: rsp_err_o=1, no RAM access.
- Misalignment:
  - Half access with addr[0]=1 is an error.
  - Word access with addr[1:0]!=0 is an error.
  - Errored stores do not modify memory.
- Address range: word index addr[31:2] >= DEPTH_WORDS is an error. No wrap-around or aliasing.
- Reserved funct3 is an error:
  - for loads, 011, 110, 111;
  - for stores, any code other than 000, 001, 010.
- Store byte-enables:
  - SB: lane addr[1:0].
  - SH: lanes {addr[1],0} and {addr[1],1}.
  - SW: all four lanes.
  - Data is replicated into the addressed lane(s); untouched lanes keep their old value.
- Load extraction: select the lane by addr[1:0] (byte) or addr[1] (half).
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- Read-after-write: a load accepted in the cycle after a store's response sees the stored data (no bypass needed; the accesses are serialized).
- Outputs registered. rsp_rdata_o and rsp_err_o return to 0 in any cycle where rsp_valid_o=0.

Test Plan:
- Reset, then SW 0xDEADBEEF to 0x10, then LW 0x10 with WAIT_CYCLES=1 -> store response err=0, rdata=0; load response 2 cycles after accept, rdata=0xDEADBEEF.
- After the above: SB 0x7F to 0x11, then LB 0x11, LBU 0x13, LH 0x12 -> memory word 0xDEAD7FEF; LB=0x0000007F, LBU=0x000000DE, LH=0xFFFFDEAD.
- LH at 0x11; SW 0x12345678 to 0x12 -> both err=1; a following LW 0x10 still returns 0xDEAD7FEF.
- Address 4*DEPTH_WORDS, and mem_read_i=mem_write_i=1, and load funct3=011 -> each gives err=1, rdata=0, no write.
- WAIT_CYCLES=0 with back-to-back requests held high -> accepts every 2nd cycle; rsp_valid_o pulses exactly once per request.
- rst_i pulsed while in WAIT of an SW to 0x20 -> outputs 0 immediately; a later LW 0x20 returns the pre-store value.

Source files
------------

// File: rtl/primus_dmem_responder.sv
// primus_dmem_responder
//   Target side of the mem_stage data-memory access interface. Accepts one
//   load or store per handshake, holds it for WAIT_CYCLES extra cycles, then
//   performs the access on a word-organised RAM and returns a one-cycle
//   response. Loads return sign/zero-extended data. Illegal, misaligned,
//   reserved-size or out-of-range requests return an error and never touch
//   the RAM.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_i        request valid, held with its fields until accepted
//   mem_read_i   load request
//   mem_write_i  store request
//   funct3_i     size code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr_i       byte address
//   wdata_i      store data, right-aligned
//   req_ready_o  request accepted when req_i is also high
//   rsp_valid_o  one-cycle response strobe
//   rsp_rdata_o  extended load data, 0 for stores/errors/idle cycles
//   rsp_err_o    access fault, qualified by rsp_valid_o
module primus_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q;
    logic        run_q;      // low during reset and the first edge after it
    logic [3:0]  cnt_q;
    logic        rd_q, wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic        rsp_valid_q, rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] rd_word_q;

    logic [31:0] mem [DEPTH_WORDS];

    // Request currently being served: the live inputs while idle (so a
    // zero-wait access can happen on the accept edge), the latched copy after.
    logic        in_idle, accept, access, we;
    logic        cur_rd, cur_wr, cur_err;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr, cur_wdata;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wrep, ext_data;
    logic        f3_ok, misalign, out_of_range;

    // run_q keeps ready low while reset is held, which also guarantees that
    // no RAM write can be triggered by a request seen during reset.
    assign req_ready_o = run_q && (state_q == S_IDLE);
    assign in_idle     = (state_q == S_IDLE);
    assign accept      = req_i && req_ready_o;

    assign cur_rd    = in_idle ? mem_read_i  : rd_q;
    assign cur_wr    = in_idle ? mem_write_i : wr_q;
    assign cur_f3    = in_idle ? funct3_i    : f3_q;
    assign cur_addr  = in_idle ? addr_i      : addr_q;
    assign cur_wdata = in_idle ? wdata_i     : wdata_q;
    assign idx       = cur_addr[AW+1:2];

    always_comb begin
        f3_ok = 1'b0;
        if (cur_wr)
            f3_ok = cur_f3 inside {3'b000, 3'b001, 3'b010};
        else
            f3_ok = cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end

    assign misalign = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                      ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    assign out_of_range = |cur_addr[31:AW+2];
    assign cur_err = (cur_rd == cur_wr) || !f3_ok || misalign || out_of_range;

    // The access edge is the one that enters RESP.
    assign access = (accept && (WAIT_CYCLES == 0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd1));
    assign we     = access && cur_wr && !cur_err;

    always_comb begin
        be   = 4'b1111;
        wrep = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                be   = 4'b0001 << cur_addr[1:0];
                wrep = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // RAM: byte-lane write, registered read, no reset.
    always_ff @(posedge clk_i) begin
        if (access)
            rd_word_q <= mem[idx];
        for (int i = 0; i < 4; i++) begin
            if (we && be[i])
                mem[idx][i*8 +: 8] <= wrep[i*8 +: 8];
        end
    end

    // Load extraction from the word read on entry to RESP.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        case (cur_addr[1:0])
            2'b00: b = rd_word_q[7:0];
            2'b01: b = rd_word_q[15:8];
            2'b10: b = rd_word_q[23:16];
            default: b = rd_word_q[31:24];
        endcase
        h = cur_addr[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        case (cur_f3)
            3'b000:  ext_data = {{24{b[7]}}, b};
            3'b001:  ext_data = {{16{h[15]}}, h};
            3'b010:  ext_data = rd_word_q;
            3'b100:  ext_data = {24'h0, b};
            3'b101:  ext_data = {16'h0, h};
            default: ext_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            cnt_q       <= 4'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rd_q    <= mem_read_i;
                        wr_q    <= mem_write_i;
                        f3_q    <= funct3_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1)
                        state_q <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= cur_err;
                    rsp_rdata_q <= (cur_rd && !cur_err) ? ext_data : 32'h0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
